mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-port data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the pipelined CPU. Accepts one request at a time, drives the memory for a parameterised number of wait cycles, and returns read data with a one-cycle valid pulse. Raises per-requester stall signals so the pipeline freezes until its access completes. Sits between the IF/MEM stage logic and the Data_Memory instance.

## Interface
Parameters:
- MEM_LATENCY, 1: cycles mem_en is held per access; legal range 1..15.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  fetch request; held until if_valid.
- if_addr  in  ADDR_W  fetch address.
- if_valid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetched word.
- if_stall  out  1  if_req & ~if_valid, combinational.
- dm_read  in  1  MemRead from MEM stage.
- dm_write  in  2  MemWrite: 00 none, 01 byte, 10 half, 11 word.
- dm_addr  in  ADDR_W  load/store address (ALU result).
- dm_wdata  in  DATA_W  store data (Read_data_2).
- dm_valid  out  1  one-cycle pulse: access done, dm_rdata valid for loads.
- dm_rdata  out  DATA_W  load data.
- dm_stall  out  1  dm_req & ~dm_valid, combinational.
- mem_en  out  1  memory access enable.
- mem_we  out  2  write size to memory, 00 on reads.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, sampled on the last access cycle.

## Operation
- dm_req = dm_read | (dm_write != 0). If both are set, the access is a write (mem_we = dm_write); read data is still captured.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: with no request, stay; mem_en = 0. With a request, pick the winner, register addr/wdata/we into the command regs, load cnt = MEM_LATENCY-1, go to ACCESS.
- ACCESS: mem_en = 1; mem_* come from the command regs. If cnt == 0, capture mem_rdata into the winner's rdata reg and go to RESP; otherwise decrement cnt.
- RESP: pulse the winner's valid for one cycle; mem_en = 0, mem_we = 0; go to IDLE.
- Arbitration defaults to fixed priority, data over fetch.
- A requester dropping its req mid-access does not abort the access; valid still pulses in RESP.
- Addresses pass through unchanged. No alignment checking.

## Timing
- Reset values: state IDLE, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, if_valid 0, dm_valid 0, if_rdata 0, dm_rdata 0, cnt 0.
- Latency: request seen in IDLE at cycle 0 → mem_en high in cycles 1..MEM_LATENCY → valid at cycle MEM_LATENCY+1.
- Throughput: one access per MEM_LATENCY+2 cycles. The next request is accepted in the IDLE cycle following RESP.
- Simultaneous if_req and dm_req in IDLE: one is granted. The loser's stall stays high through the whole access and is served next.
- rdata regs hold their value until the next completion by the same requester.
- rst asserted in any state: state IDLE, mem_en 0 after the edge, and no valid pulse for the aborted access. A write in flight may be partially committed by the memory.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration. A last_grant flop records the last winner; on contention the other requester wins. last_grant resets to "fetch", so data wins the first contention.
- MEM_ARB_RR_EN undefined: fixed data-over-fetch priority and no last_grant flop. A continuous dm_req stream can starve fetch, which is acceptable because the MEM stage stalls the pipeline.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE/ACCESS/RESP);
  - the write-size constants WR_NONE/WR_BYTE/WR_HALF/WR_WORD;
  - the grant-id constants GNT_IF/GNT_DM.
- One sub-module, mem_arb_wait_cnt: a 4-bit loadable down-counter with a zero flag that sequences ACCESS.

## Test plan
- Reset: rst high 2 cycles with if_req=1 → all registered outputs 0, if_stall=1, no mem_en; the first access starts in the cycle after rst falls.
- Lone fetch, MEM_LATENCY=1, if_addr=0x40, mem_rdata=0x12345678 → mem_en in cycle 1 only, if_valid pulse in cycle 2 with if_rdata=0x12345678.
- Word store, MEM_LATENCY=3, dm_write=11, dm_addr=0x100, dm_wdata=0xDEADBEEF → mem_we=11 and mem_addr=0x100 for 3 cycles, dm_valid at cycle 4, dm_stall low in cycle 4.
- Contention: if_req and dm_read in the same IDLE cycle, held → dm served first and if second. With MEM_ARB_RR_EN and repeated contention, grants alternate DM, IF, DM, IF.
- Mid-access reset: rst in the second ACCESS cycle (MEM_LATENCY=3) → mem_en 0 next cycle, no dm_valid, FSM back to IDLE.
- Read+write both set: dm_read=1, dm_write=01 → mem_we=01 and dm_valid pulses once.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   localparam logic [1:0] WR_NONE = 2'b00;
   localparam logic [1:0] WR_BYTE = 2'b01;
   localparam logic [1:0] WR_HALF = 2'b10;
   localparam logic [1:0] WR_WORD = 2'b11;

   localparam logic GNT_IF = 1'b0;
   localparam logic GNT_DM = 1'b1;

endpackage

// File: rtl/mem_arb_wait_cnt.sv
// 4-bit loadable down-counter with zero flag; sequences the ACCESS phase.
module mem_arb_wait_cnt (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       zero
);

   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port data memory between IF fetch and MEM load/store.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed data-over-fetch.
//   state  | meaning
//   IDLE   | no access in flight; arbitrate and latch the winner's command
//   ACCESS | mem_en held MEM_LATENCY cycles from the command regs
//   RESP   | one-cycle valid pulse to the winner
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LATENCY = 1,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_stall,
   input  logic              dm_read,
   input  logic [1:0]        dm_write,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_valid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_stall,
   output logic              mem_en,
   output logic [1:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_t        state_q, state_d;
   logic              gnt_q, gnt_d;
   logic              win;
   logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
   logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
   logic [1:0]        cmd_we_q, cmd_we_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              if_valid_q, if_valid_d;
   logic              dm_valid_q, dm_valid_d;
   logic              dm_req;
   logic              cnt_load, cnt_dec, cnt_zero;

   assign dm_req = dm_read | (dm_write != WR_NONE);

`ifdef MEM_ARB_RR_EN
   logic last_grant_q, last_grant_d;

   // On contention the requester that did not win last time goes first.
   always_comb begin
      win = dm_req ? GNT_DM : GNT_IF;
      if (dm_req && if_req) begin
         win = (last_grant_q == GNT_IF) ? GNT_DM : GNT_IF;
      end
      last_grant_d = last_grant_q;
      if ((state_q == IDLE) && (dm_req || if_req)) begin
         last_grant_d = win;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= GNT_IF;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`else
   assign win = dm_req ? GNT_DM : GNT_IF;
`endif

   mem_arb_wait_cnt u_wait_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (4'(MEM_LATENCY - 1)),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_wdata_d = cmd_wdata_q;
      cmd_we_d    = cmd_we_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      if_valid_d  = 1'b0;
      dm_valid_d  = 1'b0;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
      case (state_q)
         IDLE: begin
            if (dm_req || if_req) begin
               gnt_d    = win;
               cnt_load = 1'b1;
               state_d  = ACCESS;
               if (win == GNT_DM) begin
                  cmd_addr_d  = dm_addr;
                  cmd_wdata_d = dm_wdata;
                  cmd_we_d    = dm_write;
               end else begin
                  cmd_addr_d  = if_addr;
                  cmd_wdata_d = '0;
                  cmd_we_d    = WR_NONE;
               end
            end
         end
         ACCESS: begin
            if (cnt_zero) begin
               state_d = RESP;
               if (gnt_q == GNT_DM) begin
                  dm_rdata_d = mem_rdata;
                  dm_valid_d = 1'b1;
               end else begin
                  if_rdata_d = mem_rdata;
                  if_valid_d = 1'b1;
               end
            end else begin
               cnt_dec = 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_q       <= GNT_IF;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         cmd_we_q    <= WR_NONE;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_valid_q  <= 1'b0;
         dm_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_wdata_q <= cmd_wdata_d;
         cmd_we_q    <= cmd_we_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         if_valid_q  <= if_valid_d;
         dm_valid_q  <= dm_valid_d;
      end
   end

   assign mem_en    = (state_q == ACCESS);
   assign mem_we    = mem_en ? cmd_we_q : WR_NONE;
   assign mem_addr  = cmd_addr_q;
   assign mem_wdata = cmd_wdata_q;
   assign if_valid  = if_valid_q;
   assign dm_valid  = dm_valid_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign if_stall  = if_req & ~if_valid_q;
   assign dm_stall  = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter (MEM_ARB_RR_EN selects the round-robin model).
`timescale 1ns/1ps
module tb_mem_port_arbiter;
   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_valid;
   logic [31:0] if_rdata;
   logic        if_stall;
   logic        dm_read;
   logic [1:0]  dm_write;
   logic [31:0] dm_addr, dm_wdata;
   logic        dm_valid;
   logic [31:0] dm_rdata;
   logic        dm_stall;
   logic        mem_en;
   logic [1:0]  mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
      .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_valid(dm_valid), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Memory content is a fixed scramble of the address.
   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction
   assign mem_rdata = mem_fn(mem_addr);

   typedef struct {
      bit          is_dm;
      logic [31:0] addr;
      logic [1:0]  we;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          start;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          run = 0;
   int          run_start = 0;
   logic [31:0] held_if = '0;
   logic [31:0] held_dm = '0;
   bit          rr_last_dm = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on every valid pulse.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         exp_q.delete();
         run     = 0;
         held_if = '0;
         held_dm = '0;
      end else begin
         chk("if_stall", if_stall, if_req & ~if_valid);
         chk("dm_stall", dm_stall, (dm_read | (dm_write != 2'b00)) & ~dm_valid);
         if (mem_en) begin
            if (exp_q.size() == 0) begin
               chk("mem_en_unexpected", mem_en, 1'b0);
            end else begin
               if (run == 0) run_start = cyc;
               run++;
               chk("mem_addr", mem_addr, exp_q[0].addr);
               chk("mem_we", mem_we, exp_q[0].we);
               if (exp_q[0].we != 2'b00) chk("mem_wdata", mem_wdata, exp_q[0].wdata);
            end
         end else begin
            chk("mem_we_idle", mem_we, 2'b00);
         end
         if (if_valid || dm_valid) begin
            if (exp_q.size() == 0) begin
               chk("if_valid_unexpected", if_valid, 1'b0);
               chk("dm_valid_unexpected", dm_valid, 1'b0);
            end else begin
               e = exp_q.pop_front();
               chk("valid_who_if", if_valid, !e.is_dm);
               chk("valid_who_dm", dm_valid, e.is_dm);
               chk("access_len", run, LAT);
               chk("access_start", run_start, e.start);
               chk("valid_cycle", cyc, e.start + LAT);
               if (e.is_dm) held_dm = e.rdata;
               else         held_if = e.rdata;
            end
            run = 0;
         end
         chk("if_rdata", if_rdata, held_if);
         chk("dm_rdata", dm_rdata, held_dm);
      end
   end

   task automatic push(input bit is_dm, input int start);
      exp_t e;
      e.is_dm = is_dm;
      e.addr  = is_dm ? dm_addr : if_addr;
      e.we    = is_dm ? dm_write : 2'b00;
      e.wdata = dm_wdata;
      e.rdata = mem_fn(e.addr);
      e.start = start;
      exp_q.push_back(e);
   endtask

   // Holds each request until its valid, then drops it on the next edge.
   task automatic wait_done(input bit if_p, input bit dm_p, input bit drop_early);
      bit if_pend = if_p;
      bit dm_pend = dm_p;
      int budget  = 0;
      while ((if_pend || dm_pend) && budget < 4 * (LAT + 2)) begin
         @(negedge clk);
         if (if_valid) if_pend = 1'b0;
         if (dm_valid) dm_pend = 1'b0;
         @(posedge clk); #1;
         budget++;
         if (!if_pend) if_req = 1'b0;
         if (!dm_pend) begin dm_read = 1'b0; dm_write = 2'b00; end
         if (drop_early && budget == 1) begin
            if_req = 1'b0; dm_read = 1'b0; dm_write = 2'b00;
            if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom;
         end
      end
      if (if_pend || dm_pend) begin
         checks++;
         failures++;
         $display("FAIL round_timeout: if_pending=%0d dm_pending=%0d after %0d cycles", if_pend, dm_pend, budget);
         if_req = 1'b0; dm_read = 1'b0; dm_write = 2'b00;
      end
   endtask

   // kind: 0 fetch only, 1 data only, 2 both in the same IDLE cycle.
   task automatic do_round(input int kind, input bit drop_early);
      bit want_if = (kind != 1);
      bit want_dm = (kind != 0);
      bit first_dm;
      int issue;
      if_addr  = $urandom;
      dm_addr  = $urandom;
      dm_wdata = $urandom;
      if (want_dm) begin
         dm_write = 2'($urandom_range(0, 3));
         dm_read  = (dm_write == 2'b00) ? 1'b1 : 1'($urandom_range(0, 1));
      end else begin
         dm_write = 2'b00;
         dm_read  = 1'b0;
      end
      if_req = want_if;
      issue  = cyc;
      if (want_if && want_dm) begin
`ifdef MEM_ARB_RR_EN
         first_dm = !rr_last_dm;
`else
         first_dm = 1'b1;
`endif
         push(first_dm, issue + 1);
         push(!first_dm, issue + 1 + LAT + 2);
         rr_last_dm = !first_dm;
      end else begin
         first_dm = want_dm;
         push(first_dm, issue + 1);
         rr_last_dm = first_dm;
      end
      wait_done(want_if, want_dm, drop_early && !(want_if && want_dm));
   endtask

   initial begin
      int issue;
      rst = 1'b1; if_req = 1'b1; if_addr = 32'h40;
      dm_read = 1'b0; dm_write = 2'b00; dm_addr = '0; dm_wdata = '0;
      repeat (2) begin
         @(posedge clk); @(negedge clk);
         chk("rst_mem_en", mem_en, 1'b0);
         chk("rst_mem_we", mem_we, 2'b00);
         chk("rst_mem_addr", mem_addr, 32'h0);
         chk("rst_mem_wdata", mem_wdata, 32'h0);
         chk("rst_if_valid", if_valid, 1'b0);
         chk("rst_dm_valid", dm_valid, 1'b0);
         chk("rst_if_rdata", if_rdata, 32'h0);
         chk("rst_dm_rdata", dm_rdata, 32'h0);
         chk("rst_if_stall", if_stall, 1'b1);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      rr_last_dm = 1'b0;
      push(1'b0, cyc + 1);
      wait_done(1'b1, 1'b0, 1'b0);

      do_round(1, 1'b0);
      do_round(2, 1'b0);
      do_round(2, 1'b0);
      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         do_round(int'($urandom_range(0, 2)), $urandom_range(0, 3) == 0);
      end

      // Reset during the second ACCESS cycle of a load.
      @(posedge clk); #1;
      dm_read = 1'b1; dm_write = 2'b00; dm_addr = $urandom;
      issue = cyc;
      push(1'b1, issue + 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; dm_read = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      rr_last_dm = 1'b0;
      @(negedge clk);
      chk("mem_en_after_rst", mem_en, 1'b0);
      repeat (LAT + 3) begin
         @(negedge clk);
         chk("no_dm_valid_after_rst", dm_valid, 1'b0);
      end
      @(posedge clk); #1;
      do_round(2, 1'b0);
      do_round(2, 1'b0);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
